// File: rtl/seq_pass_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_pass_pkg
// Purpose  : Shared phase codes, controller states and y-code helper.
// Revision : 1.0
// ============================================================================
package seq_pass_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t ST0 = 2'd0;
  localparam phase_t ST1 = 2'd1;
  localparam phase_t ST2 = 2'd2;
  localparam phase_t ST3 = 2'd3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_state_t;

  function automatic logic [2:0] ycode(input phase_t ph);
    return {1'b0, ph} + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_pass_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_pass_arbiter_if
// Purpose  : Requester-side handshake and shared sequencer outputs.
// Revision : 1.0
// ============================================================================
interface seq_pass_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] branch;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic [1:0]      phase;
  logic [2:0]      y;
  logic            done;
  logic [IDW-1:0]  done_id;

  modport master (
    output req, branch,
    input  gnt, busy, phase, y, done, done_id
  );

  modport slave (
    input  req, branch,
    output gnt, busy, phase, y, done, done_id
  );
endinterface
`default_nettype wire

// File: rtl/seq_pass_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin pick: first set req after index last.
// Revision : 1.0
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            valid,
  output logic [NREQ-1:0] win,
  output logic [IDW-1:0]  win_id
);

  logic [NREQ-1:0] w_upper_mask;
  logic [NREQ-1:0] w_upper;
  logic [NREQ-1:0] w_pool;

  // Bits strictly above last; wraps to zero when last is the top index.
  assign w_upper_mask = ~((NREQ'(2) << last) - NREQ'(1));
  assign w_upper      = req & w_upper_mask;
  assign w_pool       = (|w_upper) ? w_upper : req;
  assign win          = w_pool & (~w_pool + NREQ'(1));
  assign valid        = |req;

  always_comb begin
    win_id = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win[j]) win_id = j[IDW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_pass_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seq_pass_arbiter
// Purpose  : Round-robin owner of one shared ST0..ST3 output sequencer pass.
// Revision : 1.0
// ============================================================================
module seq_pass_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clock,
  input  logic              reset,
  seq_pass_arbiter_if.slave bus
);
  import seq_pass_pkg::*;

  localparam logic [IDW-1:0] c_last_rst = IDW'(NREQ - 1);

  ctrl_state_t     r_state, w_state_nxt;
  phase_t          r_phase, w_phase_nxt;
  logic            r_br, w_br_nxt;
  logic [IDW-1:0]  r_last, w_last_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_busy;
  logic [2:0]      r_y;
  logic            r_done;
  logic [IDW-1:0]  r_done_id;

  logic            w_valid;
  logic [NREQ-1:0] w_win;
  logic [IDW-1:0]  w_win_id;
  logic            w_grant;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req    (bus.req),
    .last   (r_last),
    .valid  (w_valid),
    .win    (w_win),
    .win_id (w_win_id)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_br_nxt    = r_br;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    w_grant     = 1'b0;

    case (r_state)
      IDLE: w_grant = w_valid;
      RUN: begin
        case (r_phase)
          ST0:     w_phase_nxt = ST1;
          ST1:     w_phase_nxt = r_br ? ST2 : ST3;
          ST2:     w_phase_nxt = ST3;
          default: begin
            // ST3 doubles as the arbitration slot for the next pass.
            if (w_valid) begin
              w_grant = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_phase_nxt = ST0;
              w_gnt_nxt   = '0;
            end
          end
        endcase
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_grant) begin
      w_state_nxt = RUN;
      w_phase_nxt = ST0;
      w_last_nxt  = w_win_id;
      w_br_nxt    = |(bus.branch & w_win);
      w_gnt_nxt   = w_win;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_phase   <= ST0;
      r_br      <= 1'b0;
      r_last    <= c_last_rst;
      r_gnt     <= '0;
      r_busy    <= 1'b0;
      r_y       <= 3'd0;
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_br      <= w_br_nxt;
      r_last    <= w_last_nxt;
      r_gnt     <= w_gnt_nxt;
      r_busy    <= (w_state_nxt == RUN);
      r_y       <= (w_state_nxt == RUN) ? ycode(w_phase_nxt) : 3'd0;
      r_done    <= (w_state_nxt == RUN) && (w_phase_nxt == ST3);
      r_done_id <= ((w_state_nxt == RUN) && (w_phase_nxt == ST3)) ? w_last_nxt : '0;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.phase   = r_phase;
  assign bus.y       = r_y;
  assign bus.done    = r_done;
  assign bus.done_id = r_done_id;

endmodule
`default_nettype wire
